captcha_phase_sequencer: RTL and testbench
==========================================

# captcha_phase_sequencer

Parametrised sequencer and compositor for multi-phase CAPTCHA animations. It runs NUM_PHASES sub-blocks one at a time: challenge phases first, then a result phase. Between the last challenge phase and the result phase it compares the user's characters against the displayed characters, one character per cycle. It muxes pixel and LED data from the active phase, enforces a per-phase timeout, and retries the whole sequence up to MAX_ATTEMPTS before declaring fail.

## Interface
- NUM_PHASES, 3 — total phases; must be ≥2. Phases 0..NUM_PHASES-2 are challenge phases; NUM_PHASES-1 is the result phase.
- CHAR_COUNT, 6 — characters compared per attempt.
- CHAR_WIDTH, 5 — bits per character code.
- PASS_THRESHOLD, 6 — minimum matches to pass; must be ≤CHAR_COUNT.
- TIMEOUT_CYCLES, 0 — per-challenge-phase cycle limit; 0 disables the timeout.
- MAX_ATTEMPTS, 3 — attempts before fail; must be ≥1.

Ports:
- clock  in  1  — system clock.
- reset_n  in  1  — asynchronous, active-low reset.
- enable  in  1  — CAPTCHA running; low forces IDLE.
- phase_done  in  NUM_PHASES  — per-phase completion flag (level).
- phase_pixel_data  in  16*NUM_PHASES  — phase k occupies bits [16k+15:16k].
- phase_led  in  16*NUM_PHASES  — same packing as phase_pixel_data.
- act_chars  in  CHAR_COUNT*CHAR_WIDTH  — displayed characters; char i occupies [CHAR_WIDTH*i +: CHAR_WIDTH].
- inp_chars  in  CHAR_COUNT*CHAR_WIDTH  — user answer, same packing as act_chars.
- phase_run  out  NUM_PHASES  — one-hot run enable; sub-block k uses ~phase_run[k] as its reset.
- active_phase  out  clog2(NUM_PHASES)  — index of the running phase.
- pixel_data  out  16  — composited pixel.
- led  out  16  — composited LEDs.
- match_count  out  clog2(CHAR_COUNT+1)  — matches in the latest comparison.
- attempts  out  clog2(MAX_ATTEMPTS+1)  — failed attempts so far.
- pass, fail  out  1 each  — sticky outcome flags.

## Operation
- States: IDLE, RUN, COMPARE, RESULT, RETRY, PASS, FAIL.
- IDLE:
  - phase_run=0; counters cleared.
  - enable=1 → RUN with active_phase=0.
- RUN (phase k):
  - phase_run=1<<k.
  - phase_done[k]=1 with k<NUM_PHASES-2 → RUN phase k+1.
  - phase_done[k]=1 with k=NUM_PHASES-2 → COMPARE.
  - phase_done bits of non-active phases are ignored.
- Timeout: in RUN, the timer counts cycles. Reaching TIMEOUT_CYCLES-1 without done → RESULT with match_count=0, skipping COMPARE.
- COMPARE:
  - Lasts exactly CHAR_COUNT cycles; index i runs 0..CHAR_COUNT-1.
  - match_count increments when inp char i == act char i.
  - phase_run holds phase NUM_PHASES-2 so its outputs and chars stay stable.
  - After the last index → RESULT.
- RESULT:
  - phase_run=1<<(NUM_PHASES-1).
  - On phase_done[NUM_PHASES-1]: match_count≥PASS_THRESHOLD → PASS.
  - Otherwise attempts increments. attempts+1=MAX_ATTEMPTS → FAIL; else → RETRY.
- RETRY:
  - Lasts one cycle with phase_run=0, which resets all sub-blocks.
  - Then → RUN phase 0; timer cleared, match_count cleared.
- PASS/FAIL:
  - Terminal; phase_run keeps the result phase asserted so its screen stays visible.
  - pass or fail=1. Exit only via enable=0 or reset_n.
- pixel_data and led: phase_pixel_data/phase_led slice at active_phase in RUN, COMPARE, RESULT, PASS and FAIL. Both are 0 in IDLE and RETRY.
- Arithmetic: the comparison is a full CHAR_WIDTH equality. The counters saturate and never wrap.

## Timing
- Reset values:
  - State IDLE.
  - phase_run=0, active_phase=0, match_count=0, attempts=0.
  - pass=0, fail=0, pixel_data=0, led=0.
- All state, counters and phase_run are registered.
- pixel_data and led are combinational from registered active_phase/state, so they add zero latency to the pixel path.
- phase_done[k] sampled high at edge n → phase_run switches at edge n+1 (one-cycle handoff).
- COMPARE: entered at edge n; RESULT is active at edge n+CHAR_COUNT.
- enable=0 takes effect at the next edge: IDLE, all counters cleared, pass/fail cleared. This holds even mid-COMPARE or mid-RETRY.
- reset_n low clears everything immediately, asynchronously. Deassertion is synchronised externally.
- enable=1 together with phase_done[0]=1 on the first RUN cycle is legal; the handoff to phase 1 occurs one cycle later.

## Test plan
- Defaults, act=inp=1..6, each phase_done pulsed 10 cycles after its run → match_count=6, pass=1 after RESULT done, attempts=0, pixel_data tracks the active slice.
- act=1..6, inp=6,5,4,3,9,9 → match_count=0; after 3 attempts fail=1, attempts=3, with two one-cycle RETRY gaps where phase_run=0.
- PASS_THRESHOLD=4, five matching chars → pass=1 on the first attempt.
- TIMEOUT_CYCLES=100, phase 0 never done → RESULT entered at cycle 100 with match_count=0; attempts=1 after result done.
- enable dropped at COMPARE cycle 2 → next cycle IDLE, phase_run=0, match_count=0, pixel_data=0.
- reset_n asserted during RESULT → all outputs 0 immediately; stray phase_done on an inactive phase is ignored throughout.

Source files
------------

// File: rtl/captcha_phase_sequencer.sv
// captcha_phase_sequencer
//
// Runs a chain of CAPTCHA animation sub-blocks one at a time: challenge phases
// 0..NUM_PHASES-2, then a character comparison, then the result phase
// NUM_PHASES-1. Failed attempts restart the chain until MAX_ATTEMPTS is used up.
//
// Ports
//   clock_i              system clock
//   reset_n_i            asynchronous active-low reset
//   enable_i             run request; low returns to IDLE and clears everything
//   phase_done_i         per-phase completion level, only the active bit matters
//   phase_pixel_data_i   16 bits per phase, phase k at [16k +: 16]
//   phase_led_i          16 bits per phase, same packing
//   act_chars_i          displayed characters, char i at [CHAR_WIDTH*i +: CHAR_WIDTH]
//   inp_chars_i          user characters, same packing
//   phase_run_o          one-hot run enable; sub-block k is held in reset when low
//   active_phase_o       index of the running phase
//   pixel_data_o, led_o  data of the active phase, zero in IDLE and RETRY
//   match_count_o        matches found in the latest comparison
//   attempts_o           failed attempts so far
//   pass_o, fail_o       sticky outcome flags
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | not enabled, nothing running
// RUN     | challenge phase active_phase running, timeout timer active
// COMPARE | one character compared per cycle, last challenge phase held
// RESULT  | result phase running, waiting for its done flag
// RETRY   | one cycle with every sub-block in reset before a new attempt
// PASS    | terminal, result screen kept visible
// FAIL    | terminal, result screen kept visible
module captcha_phase_sequencer #(
    parameter int NUM_PHASES     = 3,
    parameter int CHAR_COUNT     = 6,
    parameter int CHAR_WIDTH     = 5,
    parameter int PASS_THRESHOLD = 6,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int MAX_ATTEMPTS   = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_n_i,
    input  logic                               enable_i,
    input  logic [NUM_PHASES-1:0]              phase_done_i,
    input  logic [16*NUM_PHASES-1:0]           phase_pixel_data_i,
    input  logic [16*NUM_PHASES-1:0]           phase_led_i,
    input  logic [CHAR_COUNT*CHAR_WIDTH-1:0]   act_chars_i,
    input  logic [CHAR_COUNT*CHAR_WIDTH-1:0]   inp_chars_i,
    output logic [NUM_PHASES-1:0]              phase_run_o,
    output logic [$clog2(NUM_PHASES)-1:0]      active_phase_o,
    output logic [15:0]                        pixel_data_o,
    output logic [15:0]                        led_o,
    output logic [$clog2(CHAR_COUNT+1)-1:0]    match_count_o,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]  attempts_o,
    output logic                               pass_o,
    output logic                               fail_o
);

    localparam int PH_W = $clog2(NUM_PHASES);
    localparam int MC_W = $clog2(CHAR_COUNT + 1);
    localparam int AT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int CI_W = (CHAR_COUNT > 1) ? $clog2(CHAR_COUNT) : 1;
    localparam int TM_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PH_W-1:0]       LAST_CHAL = PH_W'(NUM_PHASES - 2);
    localparam logic [PH_W-1:0]       RES_PH    = PH_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] RUN_FIRST = NUM_PHASES'(1);
    localparam logic [NUM_PHASES-1:0] RUN_RES   = RUN_FIRST << (NUM_PHASES - 1);
    localparam logic [CI_W-1:0]       CI_LAST   = CI_W'(CHAR_COUNT - 1);
    localparam logic [MC_W-1:0]       MC_MAX    = MC_W'(CHAR_COUNT);
    localparam logic [MC_W-1:0]       MC_THR    = MC_W'(PASS_THRESHOLD);
    localparam logic [AT_W-1:0]       AT_MAX    = AT_W'(MAX_ATTEMPTS);
    localparam logic [TM_W-1:0]       TM_LOAD   = TM_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_COMPARE, S_RESULT, S_RETRY, S_PASS, S_FAIL
    } state_t;

    state_t                  state_q;
    logic [NUM_PHASES-1:0]   phase_run_q;
    logic [PH_W-1:0]         active_phase_q;
    logic [MC_W-1:0]         match_count_q;
    logic [AT_W-1:0]         attempts_q;
    logic [CI_W-1:0]         cmp_idx_q;
    logic [TM_W-1:0]         timer_q;
    logic                    pass_q;
    logic                    fail_q;

    logic                    char_hit;
    logic                    timeout_hit;
    logic                    show_data;
    logic [15:0]             pixel_d;
    logic [15:0]             led_d;

    always_comb begin
        char_hit = 1'b0;
        for (int i = 0; i < CHAR_COUNT; i++) begin
            if (cmp_idx_q == CI_W'(i)) begin
                char_hit = (inp_chars_i[CHAR_WIDTH*i +: CHAR_WIDTH] ==
                            act_chars_i[CHAR_WIDTH*i +: CHAR_WIDTH]);
            end
        end
    end

    // Down-counter loaded on every phase entry; terminal count of zero means
    // TIMEOUT_CYCLES cycles have elapsed in the current challenge phase.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == '0);

    // Pixel path stays combinational so the compositor adds no latency.
    assign show_data = (state_q != S_IDLE) && (state_q != S_RETRY);

    always_comb begin
        pixel_d = '0;
        led_d   = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (show_data && (active_phase_q == PH_W'(k))) begin
                pixel_d = phase_pixel_data_i[16*k +: 16];
                led_d   = phase_led_i[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= S_IDLE;
            phase_run_q    <= '0;
            active_phase_q <= '0;
            match_count_q  <= '0;
            attempts_q     <= '0;
            cmp_idx_q      <= '0;
            timer_q        <= '0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
        end else if (!enable_i) begin
            state_q        <= S_IDLE;
            phase_run_q    <= '0;
            active_phase_q <= '0;
            match_count_q  <= '0;
            attempts_q     <= '0;
            cmp_idx_q      <= '0;
            timer_q        <= '0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_RETRY: begin
                    state_q        <= S_RUN;
                    phase_run_q    <= RUN_FIRST;
                    active_phase_q <= '0;
                    match_count_q  <= '0;
                    cmp_idx_q      <= '0;
                    timer_q        <= TM_LOAD;
                end
                S_RUN: begin
                    if (phase_done_i[active_phase_q]) begin
                        if (active_phase_q == LAST_CHAL) begin
                            // phase_run stays on the last challenge so its chars hold
                            state_q       <= S_COMPARE;
                            cmp_idx_q     <= '0;
                            match_count_q <= '0;
                        end else begin
                            phase_run_q    <= phase_run_q << 1;
                            active_phase_q <= active_phase_q + PH_W'(1);
                            timer_q        <= TM_LOAD;
                        end
                    end else if (timeout_hit) begin
                        state_q        <= S_RESULT;
                        phase_run_q    <= RUN_RES;
                        active_phase_q <= RES_PH;
                        match_count_q  <= '0;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - TM_W'(1);
                    end
                end
                S_COMPARE: begin
                    if (char_hit && (match_count_q != MC_MAX)) begin
                        match_count_q <= match_count_q + MC_W'(1);
                    end
                    if (cmp_idx_q == CI_LAST) begin
                        state_q        <= S_RESULT;
                        phase_run_q    <= RUN_RES;
                        active_phase_q <= RES_PH;
                    end else begin
                        cmp_idx_q <= cmp_idx_q + CI_W'(1);
                    end
                end
                S_RESULT: begin
                    if (phase_done_i[RES_PH]) begin
                        if (match_count_q >= MC_THR) begin
                            state_q <= S_PASS;
                            pass_q  <= 1'b1;
                        end else begin
                            if (attempts_q != AT_MAX) begin
                                attempts_q <= attempts_q + AT_W'(1);
                            end
                            if ((attempts_q + AT_W'(1)) >= AT_MAX) begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                            end else begin
                                // one cycle with every sub-block held in reset
                                state_q        <= S_RETRY;
                                phase_run_q    <= '0;
                                active_phase_q <= '0;
                            end
                        end
                    end
                end
                S_PASS, S_FAIL: begin
                    phase_run_q    <= RUN_RES;
                    active_phase_q <= RES_PH;
                end
                default: begin
                    state_q     <= S_IDLE;
                    phase_run_q <= '0;
                end
            endcase
        end
    end

    assign phase_run_o    = phase_run_q;
    assign active_phase_o = active_phase_q;
    assign pixel_data_o   = pixel_d;
    assign led_o          = led_d;
    assign match_count_o  = match_count_q;
    assign attempts_o     = attempts_q;
    assign pass_o         = pass_q;
    assign fail_o         = fail_q;

endmodule

// File: tb/tb_captcha_phase_sequencer.sv
module tb_captcha_phase_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b;
    logic [2:0]  done_a, done_b;
    logic [47:0] pix_in, led_in;
    logic [29:0] act, inp;

    logic [2:0]  run_a, run_b;
    logic [1:0]  act_a, act_b;
    logic [15:0] pix_a, pix_b, led_a, led_b;
    logic [2:0]  mc_a, mc_b;
    logic [1:0]  att_a, att_b;
    logic        pass_a, pass_b, fail_a, fail_b;

    // A: default parameters. B: threshold 4, timeout 100.
    captcha_phase_sequencer dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(en_a), .phase_done_i(done_a),
        .phase_pixel_data_i(pix_in), .phase_led_i(led_in),
        .act_chars_i(act), .inp_chars_i(inp),
        .phase_run_o(run_a), .active_phase_o(act_a), .pixel_data_o(pix_a), .led_o(led_a),
        .match_count_o(mc_a), .attempts_o(att_a), .pass_o(pass_a), .fail_o(fail_a)
    );

    captcha_phase_sequencer #(.PASS_THRESHOLD(4), .TIMEOUT_CYCLES(100)) dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(en_b), .phase_done_i(done_b),
        .phase_pixel_data_i(pix_in), .phase_led_i(led_in),
        .act_chars_i(act), .inp_chars_i(inp),
        .phase_run_o(run_b), .active_phase_o(act_b), .pixel_data_o(pix_b), .led_o(led_b),
        .match_count_o(mc_b), .attempts_o(att_b), .pass_o(pass_b), .fail_o(fail_b)
    );

    logic        sel;
    logic [2:0]  s_run;
    logic [1:0]  s_act;
    logic [15:0] s_pix, s_led;
    logic [2:0]  s_mc;
    logic [1:0]  s_att;
    logic        s_pass, s_fail;

    assign s_run  = sel ? run_b  : run_a;
    assign s_act  = sel ? act_b  : act_a;
    assign s_pix  = sel ? pix_b  : pix_a;
    assign s_led  = sel ? led_b  : led_a;
    assign s_mc   = sel ? mc_b   : mc_a;
    assign s_att  = sel ? att_b  : att_a;
    assign s_pass = sel ? pass_b : pass_a;
    assign s_fail = sel ? fail_b : fail_a;

    typedef struct {
        logic        dsel;
        logic [29:0] act;
        logic [29:0] inp;
        int          exp_match;
        logic        exp_pass;
        logic        exp_fail;
        int          exp_att;
    } vec_t;

    vec_t        vecs [8];
    int          nvec;
    int          checks = 0;
    int          errors = 0;
    int          na;
    logic [15:0] exp_pix [3];
    logic [15:0] exp_led [3];
    logic [2:0]  want;

    function automatic logic [29:0] pack6(input logic [4:0] c0, input logic [4:0] c1,
                                          input logic [4:0] c2, input logic [4:0] c3,
                                          input logic [4:0] c4, input logic [4:0] c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_run(input logic [2:0] w, input string name);
        int n;
        n = 0;
        while (s_run !== w && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(s_run), int'(w));
    endtask

    task automatic set_done(input int k, input logic v);
        if (sel) done_b[k] = v;
        else     done_a[k] = v;
    endtask

    task automatic pulse_done(input int k);
        set_done(k, 1'b1);
        @(negedge clk);
        set_done(k, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_run"},    int'(s_run), 0);
        chk({tag, "_active"}, int'(s_act), 0);
        chk({tag, "_pixel"},  int'(s_pix), 0);
        chk({tag, "_led"},    int'(s_led), 0);
        chk({tag, "_match"},  int'(s_mc), 0);
        chk({tag, "_att"},    int'(s_att), 0);
        chk({tag, "_pass"},   int'(s_pass), 0);
        chk({tag, "_fail"},   int'(s_fail), 0);
    endtask

    initial begin
        exp_pix[0] = 16'hA1A1; exp_pix[1] = 16'hB2B2; exp_pix[2] = 16'hC3C3;
        exp_led[0] = 16'h0101; exp_led[1] = 16'h0202; exp_led[2] = 16'h0404;
        pix_in = {exp_pix[2], exp_pix[1], exp_pix[0]};
        led_in = {exp_led[2], exp_led[1], exp_led[0]};

        //         dsel  act                       inp                           match pass  fail  att
        vecs[0] = '{1'b0, pack6(1,2,3,4,5,6),     pack6(1,2,3,4,5,6),           6, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, pack6(1,2,3,4,5,6),     pack6(6,5,4,3,9,9),           0, 1'b0, 1'b1, 3};
        vecs[2] = '{1'b0, pack6(1,2,3,4,5,6),     pack6(1,2,3,4,5,0),           5, 1'b0, 1'b1, 3};
        vecs[3] = '{1'b0, pack6(31,31,31,31,31,31), pack6(31,31,31,31,31,31),   6, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, pack6(1,2,3,4,5,6),     pack6(1,2,19,4,5,6),          5, 1'b0, 1'b1, 3};
        vecs[5] = '{1'b1, pack6(1,2,3,4,5,6),     pack6(1,2,3,4,5,9),           5, 1'b1, 1'b0, 0};
        vecs[6] = '{1'b1, pack6(1,2,3,4,5,6),     pack6(1,2,3,4,0,0),           4, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b1, pack6(1,2,3,4,5,6),     pack6(1,2,3,0,0,0),           3, 1'b0, 1'b1, 3};
        nvec = 8;

        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; done_a = '0; done_b = '0;
        sel = 1'b0; act = '0; inp = '0;
        #12;
        chk_all_zero("reset_a");
        sel = 1'b1;
        #1;
        chk_all_zero("reset_b");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < nvec; v++) begin
            sel = vecs[v].dsel;
            act = vecs[v].act;
            inp = vecs[v].inp;
            if (sel) en_b = 1'b1;
            else     en_a = 1'b1;
            na = vecs[v].exp_pass ? 1 : 3;
            for (int a = 0; a < na; a++) begin
                for (int k = 0; k < 2; k++) begin
                    want = 3'b001 << k;
                    wait_run(want, "run_phase");
                    chk("active_phase", int'(s_act), k);
                    chk("pixel_phase", int'(s_pix), int'(exp_pix[k]));
                    chk("led_phase", int'(s_led), int'(exp_led[k]));
                    repeat (9) @(negedge clk);
                    pulse_done(k);
                    chk("handoff_run", int'(s_run), 2);
                end
                // COMPARE occupies six cycles with phase 1 still running
                chk("compare_start_match", int'(s_mc), 0);
                repeat (5) @(negedge clk);
                chk("compare_hold", int'(s_run), 2);
                @(negedge clk);
                chk("compare_len", int'(s_run), 4);
                wait_run(3'b100, "run_result");
                chk("result_match", int'(s_mc), vecs[v].exp_match);
                chk("result_pixel", int'(s_pix), int'(exp_pix[2]));
                chk("result_led", int'(s_led), int'(exp_led[2]));
                chk("result_pass_low", int'(s_pass), 0);
                repeat (9) @(negedge clk);
                pulse_done(2);
                if (a < na - 1) begin
                    chk("retry_run", int'(s_run), 0);
                    chk("retry_pixel", int'(s_pix), 0);
                    chk("retry_att", int'(s_att), a + 1);
                end
            end
            chk("final_pass", int'(s_pass), int'(vecs[v].exp_pass));
            chk("final_fail", int'(s_fail), int'(vecs[v].exp_fail));
            chk("final_att", int'(s_att), vecs[v].exp_att);
            chk("final_match", int'(s_mc), vecs[v].exp_match);
            chk("final_run", int'(s_run), 4);
            chk("final_pixel", int'(s_pix), int'(exp_pix[2]));
            en_a = 1'b0;
            en_b = 1'b0;
            @(negedge clk);
            chk_all_zero("idle_after");
        end

        // Timeout on B: phase 0 never completes.
        sel = 1'b1;
        act = pack6(1,2,3,4,5,6);
        inp = pack6(1,2,3,4,5,6);
        en_b = 1'b1;
        @(negedge clk);
        chk("to_run0", int'(s_run), 1);
        repeat (99) @(negedge clk);
        chk("to_before", int'(s_run), 1);
        @(negedge clk);
        chk("to_result", int'(s_run), 4);
        chk("to_match", int'(s_mc), 0);
        chk("to_pixel", int'(s_pix), int'(exp_pix[2]));
        pulse_done(2);
        chk("to_retry_run", int'(s_run), 0);
        chk("to_att", int'(s_att), 1);
        en_b = 1'b0;
        @(negedge clk);

        // Enable dropped in the middle of COMPARE on A.
        sel = 1'b0;
        en_a = 1'b1;
        wait_run(3'b001, "ed_run0");
        repeat (2) @(negedge clk);
        pulse_done(0);
        wait_run(3'b010, "ed_run1");
        repeat (2) @(negedge clk);
        pulse_done(1);
        chk("ed_cmp_run", int'(s_run), 2);
        chk("ed_cmp_m0", int'(s_mc), 0);
        @(negedge clk);
        chk("ed_cmp_m1", int'(s_mc), 1);
        @(negedge clk);
        chk("ed_cmp_m2", int'(s_mc), 2);
        en_a = 1'b0;
        @(negedge clk);
        chk_all_zero("ed_idle");

        // Stray done bits on inactive phases, then async reset during RESULT.
        en_a = 1'b1;
        wait_run(3'b001, "sr_run0");
        done_a = 3'b110;
        @(negedge clk);
        done_a = 3'b000;
        chk("stray_p0", int'(s_run), 1);
        repeat (2) @(negedge clk);
        pulse_done(0);
        wait_run(3'b010, "sr_run1");
        done_a = 3'b101;
        @(negedge clk);
        done_a = 3'b000;
        chk("stray_p1", int'(s_run), 2);
        pulse_done(1);
        wait_run(3'b100, "sr_result");
        chk("sr_match", int'(s_mc), 6);
        done_a = 3'b011;
        @(negedge clk);
        done_a = 3'b000;
        chk("stray_res_run", int'(s_run), 4);
        chk("stray_res_pass", int'(s_pass), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
